// File: rtl/bp_me_trace_pkg.sv
// Trace replay shared definitions.
//   - BP_ME_TRACE_ENTRY_S(paddr_w, data_w): macro declaring the packed trace
//     entry {op, msg_type, size, addr, data} inside a parameterized module.
//   - bp_me_trace_op_e: trace opcodes.
//   - bp_me_trace_state_e: replay FSM states.
//   - e_msg_*: memory message type codes; msg_has_data() flags read types
//     whose response data is checked.
`ifndef BP_ME_TRACE_PKG_SV
`define BP_ME_TRACE_PKG_SV

`define BP_ME_TRACE_ENTRY_S(paddr_w, data_w) \
    typedef struct packed { \
        logic [3:0]        op; \
        logic [2:0]        msg_type; \
        logic [2:0]        size; \
        logic [paddr_w-1:0] addr; \
        logic [data_w-1:0]  data; \
    } bp_me_trace_entry_s

package bp_me_trace_pkg;

    typedef enum logic [3:0] {
        e_op_send   = 4'd0,
        e_op_recv   = 4'd1,
        e_op_wait   = 4'd2,
        e_op_finish = 4'd3
    } bp_me_trace_op_e;

    typedef enum logic [2:0] {
        e_st_reset,
        e_st_decode,
        e_st_send,
        e_st_recv,
        e_st_wait,
        e_st_done
    } bp_me_trace_state_e;

    localparam logic [2:0] e_msg_rd    = 3'd0;
    localparam logic [2:0] e_msg_wr    = 3'd1;
    localparam logic [2:0] e_msg_uc_rd = 3'd2;
    localparam logic [2:0] e_msg_uc_wr = 3'd3;
    localparam logic [2:0] e_msg_wb    = 3'd4;

    // Only read responses carry data worth comparing.
    function automatic logic msg_has_data(input logic [2:0] msg_type);
        return (msg_type == e_msg_rd) || (msg_type == e_msg_uc_rd);
    endfunction

endpackage

`endif

// File: rtl/bp_mem_trace_replay_cmp.sv
// Combinational response checker.
//   exp_i      : expected message {msg_type, size, addr, data}
//   act_i      : received message, same layout
//   mismatch_o : 1 when header differs, or data differs on a read type
module bp_mem_trace_replay_cmp
    import bp_me_trace_pkg::*;
#(
    parameter int paddr_width_p = 40,
    parameter int data_width_p  = 512
) (
    input  logic [6+paddr_width_p+data_width_p-1:0] exp_i,
    input  logic [6+paddr_width_p+data_width_p-1:0] act_i,
    output logic                                    mismatch_o
);
    localparam int msg_w_lp = 6 + paddr_width_p + data_width_p;

    logic hdr_mis, data_mis;

    always_comb begin
        hdr_mis    = exp_i[msg_w_lp-1:data_width_p] != act_i[msg_w_lp-1:data_width_p];
        data_mis   = exp_i[data_width_p-1:0] != act_i[data_width_p-1:0];
        mismatch_o = hdr_mis | (msg_has_data(exp_i[msg_w_lp-1 -: 3]) & data_mis);
    end

endmodule

// File: rtl/bp_mem_trace_replay.sv
// Memory trace replayer: walks a trace ROM, issuing commands, checking
// responses and inserting delays until a FINISH entry.
//   clk_i, reset_n_i       : clock, async active-low reset
//   rom_addr_o/rom_data_i  : trace ROM index (pc) and combinational entry
//   mem_cmd_o/_v_o/_ready_i: outgoing command, valid/ready
//   mem_resp_i/_v_i/_yumi_o: incoming response, valid/yumi
//   done_o, error_o, error_count_o : status
// Optional: define BP_MEM_TRACE_REPLAY_TIMEOUT_EN to abort SEND/RECV stalls
// lasting timeout_p cycles.
module bp_mem_trace_replay
    import bp_me_trace_pkg::*;
#(
    parameter int paddr_width_p    = 40,
    parameter int data_width_p     = 512,
    parameter int rom_addr_width_p = 10,
    parameter int timeout_p        = 1024
) (
    input  logic                                     clk_i,
    input  logic                                     reset_n_i,
    output logic [rom_addr_width_p-1:0]              rom_addr_o,
    input  logic [10+paddr_width_p+data_width_p-1:0] rom_data_i,
    output logic [6+paddr_width_p+data_width_p-1:0]  mem_cmd_o,
    output logic                                     mem_cmd_v_o,
    input  logic                                     mem_cmd_ready_i,
    input  logic [6+paddr_width_p+data_width_p-1:0]  mem_resp_i,
    input  logic                                     mem_resp_v_i,
    output logic                                     mem_resp_yumi_o,
    output logic                                     done_o,
    output logic                                     error_o,
    output logic [15:0]                              error_count_o
);
    localparam int msg_w_lp = 6 + paddr_width_p + data_width_p;
    localparam logic [rom_addr_width_p-1:0] pc_max_lp = '1;

    `BP_ME_TRACE_ENTRY_S(paddr_width_p, data_width_p);

    bp_me_trace_entry_s          rom_entry;
    bp_me_trace_state_e          state_r;
    logic [rom_addr_width_p-1:0] pc_r;
    logic [msg_w_lp-1:0]         exp_r;
    logic                        cmd_v_r, done_r, error_r;
    logic [15:0]                 wait_cnt_r, err_cnt_r;
    logic                        mismatch;

`ifdef BP_MEM_TRACE_REPLAY_TIMEOUT_EN
    localparam int stall_w_lp = $clog2(timeout_p + 1);
    logic [stall_w_lp-1:0] stall_r;
    wire stall_expire = (stall_r == stall_w_lp'(timeout_p - 1));
`endif

    assign rom_entry       = rom_data_i;
    assign rom_addr_o      = pc_r;
    assign mem_cmd_o       = exp_r;
    assign mem_cmd_v_o     = cmd_v_r;
    // Consumption is only possible in RECV, where cmd_v_r is never set.
    assign mem_resp_yumi_o = (state_r == e_st_recv) & mem_resp_v_i;
    assign done_o          = done_r;
    assign error_o         = error_r;
    assign error_count_o   = err_cnt_r;

    bp_mem_trace_replay_cmp #(
        .paddr_width_p(paddr_width_p),
        .data_width_p (data_width_p)
    ) cmp (
        .exp_i     (exp_r),
        .act_i     (mem_resp_i),
        .mismatch_o(mismatch)
    );

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r    <= e_st_reset;
            pc_r       <= '0;
            exp_r      <= '0;
            cmd_v_r    <= 1'b0;
            wait_cnt_r <= '0;
            done_r     <= 1'b0;
            error_r    <= 1'b0;
            err_cnt_r  <= '0;
`ifdef BP_MEM_TRACE_REPLAY_TIMEOUT_EN
            stall_r    <= '0;
`endif
        end else begin
            case (state_r)
                e_st_reset: state_r <= e_st_decode;
                e_st_decode: begin
                    exp_r <= {rom_entry.msg_type, rom_entry.size, rom_entry.addr, rom_entry.data};
                    if (rom_entry.op == e_op_finish) begin
                        state_r <= e_st_done;
                        done_r  <= 1'b1;
                    end else if (pc_r == pc_max_lp) begin
                        // Ran off the end of the ROM without a FINISH.
                        state_r <= e_st_done;
                        done_r  <= 1'b1;
                        error_r <= 1'b1;
                    end else begin
                        case (rom_entry.op)
                            e_op_send: begin
                                state_r <= e_st_send;
                                cmd_v_r <= 1'b1;
`ifdef BP_MEM_TRACE_REPLAY_TIMEOUT_EN
                                stall_r <= '0;
`endif
                            end
                            e_op_recv: begin
                                state_r <= e_st_recv;
`ifdef BP_MEM_TRACE_REPLAY_TIMEOUT_EN
                                stall_r <= '0;
`endif
                            end
                            e_op_wait: begin
                                state_r    <= e_st_wait;
                                wait_cnt_r <= rom_entry.data[15:0];
                            end
                            default: begin
                                state_r <= e_st_done;
                                done_r  <= 1'b1;
                                error_r <= 1'b1;
                            end
                        endcase
                    end
                end
                e_st_send: begin
                    if (mem_cmd_ready_i) begin
                        cmd_v_r <= 1'b0;
                        pc_r    <= pc_r + 1'b1;
                        state_r <= e_st_decode;
                    end
`ifdef BP_MEM_TRACE_REPLAY_TIMEOUT_EN
                    else if (stall_expire) begin
                        cmd_v_r <= 1'b0;
                        error_r <= 1'b1;
                        done_r  <= 1'b1;
                        state_r <= e_st_done;
                    end else begin
                        stall_r <= stall_r + 1'b1;
                    end
`endif
                end
                e_st_recv: begin
                    if (mem_resp_v_i) begin
                        if (mismatch) begin
                            error_r <= 1'b1;
                            if (err_cnt_r != 16'hFFFF) err_cnt_r <= err_cnt_r + 16'd1;
                        end
                        pc_r    <= pc_r + 1'b1;
                        state_r <= e_st_decode;
                    end
`ifdef BP_MEM_TRACE_REPLAY_TIMEOUT_EN
                    else if (stall_expire) begin
                        error_r <= 1'b1;
                        done_r  <= 1'b1;
                        state_r <= e_st_done;
                    end else begin
                        stall_r <= stall_r + 1'b1;
                    end
`endif
                end
                e_st_wait: begin
                    // Loaded count N: N decrements plus the exit cycle.
                    if (wait_cnt_r == 16'd0) begin
                        pc_r    <= pc_r + 1'b1;
                        state_r <= e_st_decode;
                    end else begin
                        wait_cnt_r <= wait_cnt_r - 16'd1;
                    end
                end
                e_st_done: ;
                default: state_r <= e_st_reset;
            endcase
        end
    end

endmodule

// File: tb/tb_bp_mem_trace_replay.sv
module tb_bp_mem_trace_replay;
    import bp_me_trace_pkg::*;

    localparam int PA = 40;
    localparam int DW = 64;
    localparam int RW = 4;
    localparam int EW = 10 + PA + DW;
    localparam int MW = 6 + PA + DW;

    logic          clk = 1'b0;
    logic          reset_n = 1'b1;
    logic [RW-1:0] rom_addr;
    logic [EW-1:0] rom_data;
    logic [MW-1:0] cmd, resp;
    logic          cmd_v, cmd_ready, resp_v, yumi, done, error;
    logic [15:0]   err_cnt;
    logic [EW-1:0] rom [16];

    int n_chk = 0, n_fail = 0, hs_cnt = 0, yumi_cnt = 0;

    always #5 clk = ~clk;
    assign rom_data = rom[rom_addr];

    always @(posedge clk) begin
        if (cmd_v && cmd_ready) hs_cnt <= hs_cnt + 1;
        if (yumi) yumi_cnt <= yumi_cnt + 1;
    end

    bp_mem_trace_replay #(
        .paddr_width_p(PA), .data_width_p(DW), .rom_addr_width_p(RW), .timeout_p(16)
    ) dut (
        .clk_i(clk), .reset_n_i(reset_n),
        .rom_addr_o(rom_addr), .rom_data_i(rom_data),
        .mem_cmd_o(cmd), .mem_cmd_v_o(cmd_v), .mem_cmd_ready_i(cmd_ready),
        .mem_resp_i(resp), .mem_resp_v_i(resp_v), .mem_resp_yumi_o(yumi),
        .done_o(done), .error_o(error), .error_count_o(err_cnt)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [EW-1:0] ent(input logic [3:0] op, input logic [2:0] mt,
                                          input logic [2:0] sz, input logic [PA-1:0] a,
                                          input logic [DW-1:0] d);
        return {op, mt, sz, a, d};
    endfunction

    function automatic logic [MW-1:0] msg(input logic [2:0] mt, input logic [2:0] sz,
                                          input logic [PA-1:0] a, input logic [DW-1:0] d);
        return {mt, sz, a, d};
    endfunction

    task automatic do_reset();
        reset_n = 1'b0; cmd_ready = 1'b0; resp_v = 1'b0; resp = '0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic wait_v(input string tag);
        int n = 0;
        while (!cmd_v && n < 20) begin @(negedge clk); n++; end
        chk(tag, 128'(cmd_v), 128'd1);
    endtask

    task automatic wait_done(input string tag, input int bound);
        int n = 0;
        while (!done && n < bound) begin @(negedge clk); n++; end
        chk(tag, 128'(done), 128'd1);
    endtask

    localparam logic [PA-1:0] A0 = 40'h80000000;
    localparam logic [DW-1:0] DD = 64'hDEADBEEF_CAFEF00D;

    initial begin
        logic [MW-1:0] cmd0;
        int stable, n;
        cmd0 = msg(e_msg_rd, 3'b110, A0, '0);
        cmd_ready = 1'b0; resp_v = 1'b0; resp = '0;

        for (int i = 0; i < 16; i++) rom[i] = ent(4'd3, 3'd0, 3'd0, '0, '0);
        rom[0] = ent(4'(e_op_send), e_msg_rd, 3'b110, A0, '0);
        rom[1] = ent(4'(e_op_recv), e_msg_rd, 3'b110, A0, DD);
        rom[2] = ent(4'(e_op_recv), e_msg_uc_wr, 3'b011, A0, '0);
        rom[3] = ent(4'(e_op_recv), e_msg_uc_wr, 3'b011, A0, '0);
        rom[4] = ent(4'(e_op_wait), 3'd0, 3'd0, '0, 64'd7);
        rom[5] = ent(4'(e_op_finish), 3'd0, 3'd0, '0, '0);

        #1 reset_n = 1'b0;
        @(negedge clk);
        chk("rst_cmd_v", 128'(cmd_v), 128'd0);
        chk("rst_yumi", 128'(yumi), 128'd0);
        chk("rst_cmd", 128'(cmd), 128'd0);
        chk("rst_pc", 128'(rom_addr), 128'd0);
        chk("rst_status", 128'({done, error, err_cnt}), 128'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // SEND with ready held low 5 cycles.
        wait_v("send_v");
        stable = 0;
        for (int i = 0; i < 6; i++) begin
            if (cmd_v && cmd == cmd0) stable++;
            if (i == 5) cmd_ready = 1'b1;
            @(negedge clk);
        end
        cmd_ready = 1'b0;
        chk("send_stable", 128'(stable), 128'd6);
        chk("send_hs", 128'(hs_cnt), 128'd1);
        chk("send_v_drop", 128'(cmd_v), 128'd0);
        chk("send_pc", 128'(rom_addr), 128'd1);

        // Response offered in DECODE must not be consumed.
        resp = msg(e_msg_rd, 3'b110, A0, DD); resp_v = 1'b1;
        chk("ign_decode", 128'(yumi), 128'd0);
        @(negedge clk);
        chk("recv_yumi", 128'(yumi), 128'd1);
        @(negedge clk);
        resp_v = 1'b0;
        chk("recv_yumi_cnt", 128'(yumi_cnt), 128'd1);
        chk("recv_ok", 128'({error, err_cnt}), 128'd0);
        chk("recv_pc", 128'(rom_addr), 128'd2);

        // uc_wr with wrong addr.
        resp = msg(e_msg_uc_wr, 3'b011, 40'h80000040, 64'h1234); resp_v = 1'b1;
        repeat (2) @(negedge clk);
        resp_v = 1'b0;
        chk("bad_addr_err", 128'(error), 128'd1);
        chk("bad_addr_cnt", 128'(err_cnt), 128'd1);
        chk("bad_addr_pc", 128'(rom_addr), 128'd3);

        // uc_wr with only data differing is not a mismatch.
        resp = msg(e_msg_uc_wr, 3'b011, A0, 64'h5555); resp_v = 1'b1;
        repeat (2) @(negedge clk);
        resp_v = 1'b0;
        chk("wr_data_ign", 128'(err_cnt), 128'd1);
        chk("wr_pc", 128'(rom_addr), 128'd4);

        // WAIT 7: one DECODE + 8 WAIT cycles at pc 4.
        n = 0;
        while (rom_addr == 4'd4 && n < 50) begin n++; @(negedge clk); end
        chk("wait_cycles", 128'(n), 128'd9);
        chk("wait_pc", 128'(rom_addr), 128'd5);

        // FINISH: absorbing DONE ignores responses.
        resp_v = 1'b1;
        @(negedge clk);
        chk("done", 128'(done), 128'd1);
        chk("done_yumi", 128'(yumi), 128'd0);
        repeat (3) @(negedge clk);
        chk("done_hold", 128'({done, cmd_v, yumi}), 128'b100);
        chk("done_err", 128'({error, err_cnt}), 128'h1_0001);

        // Reset during a stalled SEND.
        do_reset();
        wait_v("rst2_v");
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("async_cmd_v", 128'(cmd_v), 128'd0);
        chk("async_cmd", 128'(cmd), 128'd0);
        chk("async_pc", 128'(rom_addr), 128'd0);
        @(negedge clk);
        reset_n = 1'b1;
        wait_v("restart_v");
        chk("restart_cmd", 128'(cmd), 128'(cmd0));
        chk("restart_pc", 128'(rom_addr), 128'd0);
        cmd_ready = 1'b1;
        @(negedge clk);
        cmd_ready = 1'b0;
        chk("restart_adv", 128'(rom_addr), 128'd1);

        // RECV with no response for 100 cycles.
        rom[0] = ent(4'(e_op_recv), e_msg_rd, 3'b110, A0, DD);
        rom[1] = ent(4'(e_op_finish), 3'd0, 3'd0, '0, '0);
        do_reset();
        repeat (100) @(negedge clk);
`ifdef BP_MEM_TRACE_REPLAY_TIMEOUT_EN
        chk("timeout_done", 128'(done), 128'd1);
        chk("timeout_err", 128'(error), 128'd1);
`else
        chk("stall_done", 128'(done), 128'd0);
        chk("stall_pc", 128'(rom_addr), 128'd0);
        resp = msg(e_msg_rd, 3'b110, A0, DD); resp_v = 1'b1;
        @(negedge clk);
        resp_v = 1'b0;
        chk("stall_resume_pc", 128'(rom_addr), 128'd1);
        wait_done("stall_finish", 10);
        chk("stall_no_err", 128'(error), 128'd0);
`endif

        // Unknown op.
        rom[0] = ent(4'd7, 3'd0, 3'd0, '0, '0);
        do_reset();
        wait_done("unk_done", 10);
        chk("unk_err", 128'({error, err_cnt}), 128'h1_0000);
        chk("unk_pc", 128'(rom_addr), 128'd0);

        // No FINISH anywhere: overflow at last ROM index.
        for (int i = 0; i < 16; i++) rom[i] = ent(4'(e_op_wait), 3'd0, 3'd0, '0, '0);
        do_reset();
        wait_done("ovf_done", 100);
        chk("ovf_err", 128'(error), 128'd1);
        chk("ovf_pc", 128'(rom_addr), 128'd15);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/bp_mem_trace_replay.md
BP_MEM_TRACE_REPLAY -- requirements
Module: bp_mem_trace_replay

Interface
REQ-001 SHALL have parameter paddr_width_p, default 40, physical address width.
REQ-002 SHALL have parameter data_width_p, default 512, memory message data width.
REQ-003 SHALL have parameter rom_addr_width_p, default 10, trace ROM index width.
REQ-004 SHALL have parameter timeout_p, default 1024, stall cycles before timeout; used only under REQ-026.
REQ-005 SHALL have ports, clock and reset first:
- clk_i  in  1  single clock; all logic on posedge.
- reset_n_i  in  1  reset, asynchronous, active-low.
- rom_addr_o  out  rom_addr_width_p  trace entry index (pc).
- rom_data_i  in  entry width  trace entry, combinational read of rom_addr_o.
- mem_cmd_o  out  3+3+paddr_width_p+data_width_p  {msg_type, size, addr, data}.
- mem_cmd_v_o  out  1  command valid.
- mem_cmd_ready_i  in  1  command ready.
- mem_resp_i  in  same as mem_cmd_o  response message.
- mem_resp_v_i  in  1  response valid.
- mem_resp_yumi_o  out  1  response consumed.
- done_o  out  1  replay finished.
- error_o  out  1  sticky mismatch/fault flag.
- error_count_o  out  16  mismatch count.

Function
REQ-006 Entry SHALL be {op[3:0], msg_type[2:0], size[2:0], addr, data}; ops: SEND=0, RECV=1, WAIT=2, FINISH=3.
REQ-007 State machine SHALL use states RESET, DECODE, SEND, RECV, WAIT, DONE.
REQ-008 RESET SHALL go to DECODE on the first clock after reset deasserts, pc=0.
REQ-009 DECODE SHALL latch the entry at pc into registers and go to the op's state in 1 cycle.
REQ-010 SEND SHALL drive mem_cmd_o from latched fields with mem_cmd_v_o=1, and SHALL hold both stable until mem_cmd_ready_i=1.
REQ-011 On mem_cmd_v_o & mem_cmd_ready_i, SEND SHALL increment pc and go to DECODE.
REQ-012 RECV SHALL assert mem_resp_yumi_o equal to mem_resp_v_i, consuming exactly one response.
REQ-013 On consume, SHALL compare msg_type, size, addr always, and data only when msg_type is rd (0) or uc_rd (2).
REQ-014 On mismatch, SHALL set error_o and increment error_count_o, saturating at 16'hFFFF.
REQ-015 After any consume, RECV SHALL increment pc and go to DECODE.
REQ-016 WAIT SHALL load a counter with data[15:0] and decrement to 0, then increment pc and go to DECODE; a count of N costs N+1 cycles in WAIT.
REQ-017 FINISH, an unknown op, or pc reaching 2^rom_addr_width_p-1 without FINISH SHALL go to DONE; unknown op and pc overflow also set error_o.
REQ-018 DONE SHALL be absorbing: done_o=1, mem_cmd_v_o=0, mem_resp_yumi_o=0.
REQ-019 mem_resp_v_i outside RECV SHALL be ignored and not consumed.
REQ-020 mem_cmd_v_o SHALL never be asserted in the same cycle as mem_resp_yumi_o.

Reset
REQ-021 On reset assertion, at any state including mid-handshake, SHALL immediately set state=RESET, pc=0, mem_cmd_v_o=0, mem_resp_yumi_o=0.
REQ-022 Reset SHALL also clear done_o=0, error_o=0, error_count_o=0, WAIT counter=0, and mem_cmd_o=0.
REQ-023 A SEND interrupted by reset SHALL restart from entry 0 with no partial-command retention.

Configuration
REQ-024 Macro BP_MEM_TRACE_REPLAY_TIMEOUT_EN SHALL enable a stall counter.
REQ-025 With the macro, the counter SHALL clear on entering SEND/RECV and increment each stalled cycle.
REQ-026 With the macro, reaching timeout_p SHALL set error_o and go to DONE.
REQ-027 Without the macro, the counter logic SHALL be absent, and SEND/RECV SHALL wait indefinitely.

Structure
REQ-028 Package bp_me_trace_pkg SHALL hold the op enum, the trace entry struct macro, and the message type constants rd=0, wr=1, uc_rd=2, uc_wr=3, wb=4.
REQ-029 Response comparison SHALL reside in sub-module bp_mem_trace_replay_cmp, which is combinational and outputs a mismatch signal.

Verification
REQ-030 SEND rd addr 0x80000000 size 3'b110, ready held low 5 cycles -> cmd stable 6 cycles, one handshake, pc=1.
REQ-031 RECV rd expecting data 0xDEAD..., response matching -> yumi 1 cycle, error_o=0, count=0.
REQ-032 RECV uc_wr response with wrong addr 0x80000040 -> error_o=1, count=1; data differing is ignored for wr.
REQ-033 WAIT data=7 -> exactly 8 cycles in WAIT, then DECODE.
REQ-034 Reset asserted during SEND stall -> mem_cmd_v_o=0 asynchronously; after release, replay restarts at pc=0.
REQ-035 Timeout macro defined, timeout_p=16, RECV with no response -> error_o=1 and done_o=1 after 16 cycles; without the macro -> still in RECV after 100 cycles.
